// File: rtl/triangle_assembler.sv
// Loads one model's vertices into a local RAM, then walks the face stream and
// emits one assembled triangle (three full vertices + last flag) per face.
module triangle_assembler #(
    parameter int COORD_WIDTH       = 24,
    parameter int VERTEX_DATA_WIDTH = COORD_WIDTH * 3,
    parameter int INDEX_WIDTH       = 12,
    parameter int INDEX_DATA_WIDTH  = INDEX_WIDTH * 3,
    parameter int LOCAL_ADDR_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         index_error,
    output logic                         overflow,
    input  logic                         reader_ready,
    output logic                         vertex_read_en,
    input  logic [VERTEX_DATA_WIDTH-1:0] vertex_data,
    input  logic                         vertex_dv,
    input  logic                         vertex_last,
    output logic                         index_read_en,
    input  logic [INDEX_DATA_WIDTH-1:0]  index_data,
    input  logic                         index_dv,
    input  logic                         index_last,
    output logic                         tri_valid,
    input  logic                         tri_ready,
    output logic [VERTEX_DATA_WIDTH-1:0] tri_v0,
    output logic [VERTEX_DATA_WIDTH-1:0] tri_v1,
    output logic [VERTEX_DATA_WIDTH-1:0] tri_v2,
    output logic                         tri_last
);
    localparam int DEPTH = 1 << LOCAL_ADDR_WIDTH;
    localparam logic [LOCAL_ADDR_WIDTH:0] FULL_COUNT = {1'b1, {LOCAL_ADDR_WIDTH{1'b0}}};

    typedef enum logic [3:0] {
        S_IDLE, S_VLOAD, S_VDRAIN, S_FREQ, S_FWAIT,
        S_RD0, S_RD1, S_RD2, S_RD3, S_OUT, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [LOCAL_ADDR_WIDTH:0]      wr_ptr_q, wr_ptr_d;
    logic                           overflow_q, overflow_d;
    logic                           index_error_q, index_error_d;
    logic                           face_last_q, face_last_d;
    logic [INDEX_WIDTH-1:0]         idx_q [3];
    logic [INDEX_WIDTH-1:0]         idx_d [3];
    logic [VERTEX_DATA_WIDTH-1:0]   vert_q [3];
    logic [VERTEX_DATA_WIDTH-1:0]   vert_d [3];
    logic [INDEX_WIDTH-1:0]         face_field [3];

    logic [VERTEX_DATA_WIDTH-1:0]   ram [DEPTH];
    logic [VERTEX_DATA_WIDTH-1:0]   ram_rd_q;
    logic                           ram_we;
    logic [INDEX_WIDTH-1:0]         rd_idx;
    logic [LOCAL_ADDR_WIDTH-1:0]    rd_addr;
    logic                           capturing;
    logic [1:0]                     cap_sel;
    logic [INDEX_WIDTH-1:0]         cap_idx;
    logic                           cap_oob;
    logic [VERTEX_DATA_WIDTH-1:0]   cap_vert;

    // i0 sits in the MSBs of a face word, i2 in the LSBs
    for (genvar gi = 0; gi < 3; gi++) begin : g_face_split
        assign face_field[gi] = index_data[(2-gi)*INDEX_WIDTH +: INDEX_WIDTH];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start && reader_ready) state_d = S_VLOAD;
            S_VLOAD:  if (vertex_last) state_d = S_VDRAIN;
            S_VDRAIN: state_d = S_FREQ;
            S_FREQ:   state_d = S_FWAIT;
            S_FWAIT:  if (index_dv) state_d = S_RD0;
            S_RD0:    state_d = S_RD1;
            S_RD1:    state_d = S_RD2;
            S_RD2:    state_d = S_RD3;
            S_RD3:    state_d = S_OUT;
            S_OUT:    if (tri_ready) state_d = face_last_q ? S_DONE : S_FREQ;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_DONE);
        vertex_read_en = (state_q == S_VLOAD);
        index_read_en  = (state_q == S_FREQ);
        tri_valid      = (state_q == S_OUT);
        tri_last       = (state_q == S_OUT) && face_last_q;
    end

    // RAM address is presented in RD0..RD2; the registered word is captured one state later
    always_comb begin
        case (state_q)
            S_RD0:   rd_idx = idx_q[0];
            S_RD1:   rd_idx = idx_q[1];
            default: rd_idx = idx_q[2];
        endcase
        rd_addr   = rd_idx[LOCAL_ADDR_WIDTH-1:0];
        capturing = (state_q == S_RD1) || (state_q == S_RD2) || (state_q == S_RD3);
        case (state_q)
            S_RD1:   cap_sel = 2'd0;
            S_RD2:   cap_sel = 2'd1;
            default: cap_sel = 2'd2;
        endcase
        cap_idx  = idx_q[cap_sel];
        cap_oob  = 32'(cap_idx) >= 32'(wr_ptr_q);
        cap_vert = cap_oob ? '0 : ram_rd_q;
    end

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        overflow_d    = overflow_q;
        index_error_d = index_error_q;
        face_last_d   = face_last_q;
        idx_d         = idx_q;
        vert_d        = vert_q;
        ram_we        = 1'b0;

        if (state_q == S_IDLE && start && reader_ready) begin
            wr_ptr_d      = '0;
            overflow_d    = 1'b0;
            index_error_d = 1'b0;
        end

        // The count saturates at the RAM depth; extra vertices are dropped and flagged
        if ((state_q == S_VLOAD || state_q == S_VDRAIN) && vertex_dv) begin
            if (wr_ptr_q == FULL_COUNT) begin
                overflow_d = 1'b1;
            end else begin
                ram_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end

        if (state_q == S_FREQ) face_last_d = index_last;
        if (state_q == S_FWAIT && index_dv) idx_d = face_field;

        if (capturing) begin
            vert_d[cap_sel] = cap_vert;
            if (cap_oob) index_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q      <= '0;
            overflow_q    <= 1'b0;
            index_error_q <= 1'b0;
            face_last_q   <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                idx_q[k]  <= '0;
                vert_q[k] <= '0;
            end
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            overflow_q    <= overflow_d;
            index_error_q <= index_error_d;
            face_last_q   <= face_last_d;
            idx_q         <= idx_d;
            vert_q        <= vert_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram[wr_ptr_q[LOCAL_ADDR_WIDTH-1:0]] <= vertex_data;
        ram_rd_q <= ram[rd_addr];
    end

    assign index_error = index_error_q;
    assign overflow    = overflow_q;
    assign tri_v0      = vert_q[0];
    assign tri_v1      = vert_q[1];
    assign tri_v2      = vert_q[2];
endmodule

// File: doc/triangle_assembler.md
# triangle_assembler

Sits directly downstream of the model ROM reader. Drains one model's vertex stream into a local vertex RAM, then walks the model's face (index) stream and emits one assembled triangle per face: three full vertices plus a last flag, over a valid/ready handshake, to the transform/raster stage.

## Interface
- COORD_WIDTH, 24: bits per coordinate.
- VERTEX_DATA_WIDTH, COORD_WIDTH*3: one packed vertex {x,y,z}.
- INDEX_WIDTH, 12: bits per face index field.
- INDEX_DATA_WIDTH, INDEX_WIDTH*3: one face {i0,i1,i2}; i0 in MSBs, i2 in LSBs.
- LOCAL_ADDR_WIDTH, 8: local vertex RAM depth = 1<<LOCAL_ADDR_WIDTH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  begin assembling the selected model; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last triangle handshakes.
- index_error  out  1  sticky: a face index was out of range; cleared by reset or accepted start.
- overflow  out  1  sticky: model had more than 1<<LOCAL_ADDR_WIDTH vertices; cleared as index_error.
- reader_ready  in  1  upstream reader has loaded its header.
- vertex_read_en  out  1  request next vertex (data returns next cycle).
- vertex_data  in  VERTEX_DATA_WIDTH  returned vertex.
- vertex_dv  in  1  vertex_data valid.
- vertex_last  in  1  the address being requested this cycle is the model's final vertex.
- index_read_en  out  1  request next face.
- index_data  in  INDEX_DATA_WIDTH  returned face.
- index_dv  in  1  index_data valid.
- index_last  in  1  the face being requested this cycle is the final face.
- tri_valid  out  1  triangle output valid.
- tri_ready  in  1  downstream accepts.
- tri_v0, tri_v1, tri_v2  out  VERTEX_DATA_WIDTH each  vertices for i0, i1, i2.
- tri_last  out  1  this triangle is the model's last face.

## Operation
- Reset: state IDLE; all outputs 0; write pointer 0; flags cleared.
- IDLE: start && reader_ready -> VLOAD; clear index_error, overflow, wr_ptr. start without reader_ready is ignored (not queued).
- VLOAD: vertex_read_en=1 every cycle. Cycle with vertex_last=1 is the final request -> VDRAIN.
- Every vertex_dv (VLOAD or VDRAIN): write vertex_data to RAM[wr_ptr], wr_ptr+1. Saturated count: if wr_ptr already = depth, write dropped and overflow set. vertex_count = number written (LOCAL_ADDR_WIDTH+1 bits).
- VDRAIN: one cycle (absorbs final dv) -> FREQ.
- FREQ: index_read_en=1 for one cycle; latch index_last into face_last -> FWAIT.
- FWAIT: on index_dv latch i0,i1,i2 -> RD0. (index_dv arrives in this cycle; no other wait.)
- RD0/RD1/RD2: present i0/i1/i2 to RAM (1-cycle sync read). RD1 captures v0, RD2 captures v1, RD3 captures v2 -> OUT.
- Range check per index: idx >= vertex_count -> captured vertex forced to 0, index_error set.
- OUT: tri_valid=1, tri_last=face_last, vertex outputs held stable until tri_ready. On handshake: face_last ? DONE : FREQ.
- DONE: done=1 for one cycle -> IDLE.
- Models have >= 1 vertex and >= 1 face; one pass per upstream reset (reader does not rewind).

## Timing
- Vertex load: N vertices -> N request cycles + 1 drain; first FREQ at cycle N+1 after entering VLOAD.
- Face: FREQ at cycle t -> tri_valid at t+6 (FWAIT t+1, RD0 t+2, RD1 t+3, RD2 t+4, RD3 t+5, OUT t+6).
- tri_ready held high: one triangle per 7 cycles; next FREQ the cycle after handshake.
- tri_ready low: outputs and tri_valid stable; no upstream reads issued.
- tri_valid never depends combinationally on tri_ready.
- Async reset mid-operation: immediate return to IDLE, outputs 0, no further read_en.

## Test plan
- 3 vertices (1,2,3),(4,5,6),(7,8,9), one face {2,0,1}, tri_ready=1 -> 3 vertex_read_en pulses, tri_valid 6 cycles after FREQ with v0=(7,8,9), v1=(1,2,3), v2=(4,5,6), tri_last=1, done pulse next cycle.
- 4 vertices, 3 faces, tri_ready low 5 cycles on face 2 -> outputs stable throughout stall, no index_read_en during stall, tri_last only on face 3.
- Face {0,5,1} with 3 vertices -> tri_v1=0, index_error=1 sticky, remains 1 after done until next start.
- LOCAL_ADDR_WIDTH=2, 6 vertices -> overflow=1, first 4 stored, faces referencing 0..3 correct.
- start while reader_ready=0 -> stays IDLE, busy=0; reader_ready rises with start -> VLOAD next cycle.
- rstn low during RD1 -> all outputs 0 immediately, IDLE after release, no read_en asserted.
